// File: rtl/fwd_hazard_unit.sv
// rtl/fwd_hazard_unit.sv - operand forwarding and load-use hazard unit
//
// Purpose: computes per-operand bypass selects for the instruction in ID,
// registers them into EX, and inserts LOAD_STALL bubbles per load-use hazard
// while holding PC and IF/ID.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   hold_i                global freeze; all state holds, stall_o forced low
//   id_valid_i            ID holds a real instruction
//   id_src_i/id_src_use_i ID source registers (packed) and per-operand read flags
//   ex_*/mem_*/wb_*       destination register and write flags per stage
//   src_sel_o             registered EX selects: 00 rf, 10 EX/MEM, 01 MEM/WB, 11 WB latch
//   bubble_o              registered; EX holds an inserted bubble
//   stall_o               combinational; hold PC and IF/ID this cycle
//   stall_cnt_o           saturating count of inserted bubble cycles
//   fwd_cnt_o             saturating count of launches with any non-00 select
module fwd_hazard_unit #(
  parameter int REG_AW     = 5,
  parameter int NUM_SRC    = 2,
  parameter int WB_BYPASS  = 0,
  parameter int LOAD_STALL = 1,
  parameter int CNT_W      = 16
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        hold_i,
  input  logic                        id_valid_i,
  input  logic [NUM_SRC*REG_AW-1:0]   id_src_i,
  input  logic [NUM_SRC-1:0]          id_src_use_i,
  input  logic [REG_AW-1:0]           ex_rd_i,
  input  logic                        ex_w_i,
  input  logic                        ex_load_i,
  input  logic [REG_AW-1:0]           mem_rd_i,
  input  logic                        mem_w_i,
  input  logic [REG_AW-1:0]           wb_rd_i,
  input  logic                        wb_w_i,
  output logic [NUM_SRC*2-1:0]        src_sel_o,
  output logic                        bubble_o,
  output logic                        stall_o,
  output logic [CNT_W-1:0]            stall_cnt_o,
  output logic [CNT_W-1:0]            fwd_cnt_o
);

  typedef enum logic {RUN, STALL} state_t;

  state_t                 state_q, state_d;
  logic [1:0]             cnt_q, cnt_d;
  logic [NUM_SRC-1:0]     ex_m, mem_m, wb_m;
  logic [NUM_SRC*2-1:0]   sel_c;
  logic                   hazard;
  logic                   stall_c;

  genvar k;
  for (k = 0; k < NUM_SRC; k++) begin : g_src
    logic [REG_AW-1:0] src;
    logic              qual;
    assign src  = id_src_i[k*REG_AW +: REG_AW];
    assign qual = id_valid_i & id_src_use_i[k];
    // A zero destination is never a producer, so r0 reads always use the regfile.
    assign ex_m[k]  = qual & ex_w_i  & (ex_rd_i  != '0) & (ex_rd_i  == src);
    assign mem_m[k] = qual & mem_w_i & (mem_rd_i != '0) & (mem_rd_i == src);
    assign wb_m[k]  = qual & wb_w_i  & (wb_rd_i  != '0) & (wb_rd_i  == src);
    assign sel_c[2*k +: 2] = (ex_m[k] & ~ex_load_i)            ? 2'b10 :
                             mem_m[k]                          ? 2'b01 :
                             (wb_m[k] && (WB_BYPASS != 0))     ? 2'b11 :
                                                                 2'b00;
  end

  assign hazard = ex_load_i & (|ex_m);

  // stall_c doubles as "this edge launches a bubble" when not holding.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall_c = 1'b0;
    if (!hold_i) begin
      if (state_q == STALL && cnt_q != 2'd0) begin
        stall_c = 1'b1;
        cnt_d   = cnt_q - 2'd1;
      end else if (hazard) begin
        // Also covers the release cycle of a stall, so back-to-back loads re-stall.
        stall_c = 1'b1;
        if (LOAD_STALL > 1) begin
          state_d = STALL;
          cnt_d   = 2'(LOAD_STALL - 1);
        end else begin
          state_d = RUN;
          cnt_d   = 2'd0;
        end
      end else begin
        state_d = RUN;
      end
    end
  end

  assign stall_o = stall_c & ~rst_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= RUN;
      cnt_q       <= 2'd0;
      src_sel_o   <= '0;
      bubble_o    <= 1'b1;
      stall_cnt_o <= '0;
      fwd_cnt_o   <= '0;
    end else if (!hold_i) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (stall_c) begin
        src_sel_o <= '0;
        bubble_o  <= 1'b1;
        if (stall_cnt_o != '1) stall_cnt_o <= stall_cnt_o + 1'b1;
      end else begin
        src_sel_o <= sel_c;
        bubble_o  <= ~id_valid_i;
        if ((|sel_c) && (fwd_cnt_o != '1)) fwd_cnt_o <= fwd_cnt_o + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb/tb_fwd_hazard_unit.sv - self-checking bench for fwd_hazard_unit
module tb_fwd_hazard_unit;

  logic        clk = 1'b0;
  logic        rst, hold, valid, exw, exl, mw, ww;
  logic [4:0]  s0, s1, exr, mr, wr;
  logic [1:0]  u;
  logic [3:0]  sel0, sel1;
  logic        bub0, bub1, st0, st1;
  logic [15:0] sc0, fc0;
  logic [3:0]  sc1, fc1;

  int checks = 0;
  int errors = 0;
  int exp_f0 = 0;
  int exp_f1 = 0;

  always #5 clk = ~clk;

  // dut0: default build; dut1: WB bypass, 3-bubble stalls, 4-bit counters.
  fwd_hazard_unit dut0 (
    .clk_i(clk), .rst_i(rst), .hold_i(hold), .id_valid_i(valid),
    .id_src_i({s1, s0}), .id_src_use_i(u),
    .ex_rd_i(exr), .ex_w_i(exw), .ex_load_i(exl),
    .mem_rd_i(mr), .mem_w_i(mw), .wb_rd_i(wr), .wb_w_i(ww),
    .src_sel_o(sel0), .bubble_o(bub0), .stall_o(st0),
    .stall_cnt_o(sc0), .fwd_cnt_o(fc0)
  );

  fwd_hazard_unit #(.WB_BYPASS(1), .LOAD_STALL(3), .CNT_W(4)) dut1 (
    .clk_i(clk), .rst_i(rst), .hold_i(hold), .id_valid_i(valid),
    .id_src_i({s1, s0}), .id_src_use_i(u),
    .ex_rd_i(exr), .ex_w_i(exw), .ex_load_i(exl),
    .mem_rd_i(mr), .mem_w_i(mw), .wb_rd_i(wr), .wb_w_i(ww),
    .src_sel_o(sel1), .bubble_o(bub1), .stall_o(st1),
    .stall_cnt_o(sc1), .fwd_cnt_o(fc1)
  );

  typedef struct {
    logic [4:0] s0, s1;
    logic [1:0] u;
    logic       valid;
    logic [4:0] exr; logic exw;
    logic [4:0] mr;  logic mw;
    logic [4:0] wr;  logic ww;
    logic [3:0] e0, e1;
    logic       eb;
  } vec_t;

  vec_t vt[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    valid = 1'b1; s0 = 5'd0; s1 = 5'd0; u = 2'b00;
    exr = 5'd0; exw = 1'b0; exl = 1'b0;
    mr = 5'd0; mw = 1'b0; wr = 5'd0; ww = 1'b0;
  endtask

  initial begin
    //            s0 s1 u     v   exr ew mr mw wr  ww e0       e1       eb
    vt[0] = '{5'd3,  5'd0,  2'b01, 1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd0,  1'b0, 4'b0010, 4'b0010, 1'b0};
    vt[1] = '{5'd7,  5'd3,  2'b10, 1'b1, 5'd3, 1'b1, 5'd3, 1'b1, 5'd0,  1'b0, 4'b1000, 4'b1000, 1'b0};
    vt[2] = '{5'd7,  5'd3,  2'b10, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3,  1'b1, 4'b0000, 4'b1100, 1'b0};
    vt[3] = '{5'd4,  5'd4,  2'b11, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 5'd0,  1'b0, 4'b0101, 4'b0101, 1'b0};
    vt[4] = '{5'd0,  5'd0,  2'b01, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0,  1'b1, 4'b0000, 4'b0000, 1'b0};
    vt[5] = '{5'd3,  5'd0,  2'b00, 1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd0,  1'b0, 4'b0000, 4'b0000, 1'b0};
    vt[6] = '{5'd3,  5'd0,  2'b01, 1'b0, 5'd3, 1'b1, 5'd0, 1'b0, 5'd0,  1'b0, 4'b0000, 4'b0000, 1'b1};
    vt[7] = '{5'd6,  5'd0,  2'b01, 1'b1, 5'd6, 1'b0, 5'd6, 1'b1, 5'd0,  1'b0, 4'b0001, 4'b0001, 1'b0};
    vt[8] = '{5'd9,  5'd10, 2'b11, 1'b1, 5'd2, 1'b1, 5'd9, 1'b1, 5'd10, 1'b1, 4'b0001, 4'b1101, 1'b0};
    vt[9] = '{5'd2,  5'd2,  2'b11, 1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd0,  1'b0, 4'b1010, 4'b1010, 1'b0};

    rst = 1'b1; hold = 1'b0; clr();
    tick(); tick();
    chk("rst_stall0", st0, 0);  chk("rst_stall1", st1, 0);
    chk("rst_sel0", sel0, 0);   chk("rst_bub0", bub0, 1);
    chk("rst_bub1", bub1, 1);   chk("rst_sc0", sc0, 0);
    chk("rst_fc0", fc0, 0);     chk("rst_fc1", fc1, 0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      valid = vt[i].valid; s0 = vt[i].s0; s1 = vt[i].s1; u = vt[i].u;
      exr = vt[i].exr; exw = vt[i].exw; exl = 1'b0;
      mr = vt[i].mr; mw = vt[i].mw; wr = vt[i].wr; ww = vt[i].ww;
      #1;
      chk($sformatf("v%0d_stall0", i), st0, 0);
      chk($sformatf("v%0d_stall1", i), st1, 0);
      tick();
      if (vt[i].e0 != 4'b0) exp_f0++;
      if (vt[i].e1 != 4'b0 && exp_f1 < 15) exp_f1++;
      chk($sformatf("v%0d_sel0", i), sel0, vt[i].e0);
      chk($sformatf("v%0d_sel1", i), sel1, vt[i].e1);
      chk($sformatf("v%0d_bub0", i), bub0, vt[i].eb);
      chk($sformatf("v%0d_bub1", i), bub1, vt[i].eb);
      chk($sformatf("v%0d_fc0", i), fc0, exp_f0);
      chk($sformatf("v%0d_fc1", i), fc1, exp_f1);
    end

    // Load-use: load rd5 in EX, ID reads r5.
    clr(); s0 = 5'd5; u = 2'b01; exr = 5'd5; exw = 1'b1; exl = 1'b1;
    #1; chk("lu_stall0", st0, 1); chk("lu_stall1", st1, 1);
    tick();
    chk("lu_bub0", bub0, 1); chk("lu_sel0", sel0, 0); chk("lu_sc0", sc0, 1);
    chk("lu_bub1", bub1, 1); chk("lu_sc1", sc1, 1);
    // Load moves to MEM; EX now holds the bubble.
    exw = 1'b0; exl = 1'b0; mr = 5'd5; mw = 1'b1;
    #1; chk("lu2_stall0", st0, 0); chk("lu2_stall1", st1, 1);
    tick(); exp_f0++;
    chk("lu2_sel0", sel0, 4'b0001); chk("lu2_bub0", bub0, 0); chk("lu2_fc0", fc0, exp_f0);
    chk("lu2_bub1", bub1, 1); chk("lu2_sc1", sc1, 2);
    mw = 1'b0; wr = 5'd5; ww = 1'b1;
    #1; chk("lu3_stall1", st1, 1);
    tick();
    chk("lu3_bub1", bub1, 1); chk("lu3_sc1", sc1, 3); chk("lu3_sel0", sel0, 0);
    ww = 1'b0;
    #1; chk("lu4_stall1", st1, 0);
    tick();
    chk("lu4_sel1", sel1, 0); chk("lu4_bub1", bub1, 0);
    chk("lu4_sc1", sc1, 3); chk("lu4_sc0", sc0, 1); chk("lu4_fc1", fc1, exp_f1);

    // Hold in the middle of a stall.
    exr = 5'd5; exw = 1'b1; exl = 1'b1;
    tick();
    chk("h0_sc0", sc0, 2); chk("h0_sc1", sc1, 4);
    exw = 1'b0; exl = 1'b0; mr = 5'd5; mw = 1'b1; hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1; chk("hold_stall1", st1, 0); chk("hold_stall0", st0, 0);
      tick();
      chk("hold_bub1", bub1, 1); chk("hold_sc1", sc1, 4);
      chk("hold_sel0", sel0, 0); chk("hold_sc0", sc0, 2);
    end
    hold = 1'b0;
    #1; chk("unhold_stall1", st1, 1); chk("unhold_stall0", st0, 0);
    tick(); exp_f0++;
    chk("unhold_sc1", sc1, 5); chk("unhold_sel0", sel0, 4'b0001); chk("unhold_fc0", fc0, exp_f0);

    // Reset while dut1 still has one bubble to go.
    rst = 1'b1;
    #1; chk("rs_stall1", st1, 0);
    tick();
    chk("rs_bub1", bub1, 1); chk("rs_sc1", sc1, 0); chk("rs_fc1", fc1, 0);
    chk("rs_sc0", sc0, 0); chk("rs_fc0", fc0, 0); chk("rs_sel1", sel1, 0);
    rst = 1'b0; exp_f0 = 0; exp_f1 = 0; mw = 1'b0;
    #1; chk("rs_abort_stall1", st1, 0);

    // Back-to-back loads: a new hazard in dut1's release cycle.
    exr = 5'd5; exw = 1'b1; exl = 1'b1;
    tick();
    exw = 1'b0; exl = 1'b0;
    tick(); tick();
    s0 = 5'd7; exr = 5'd7; exw = 1'b1; exl = 1'b1;
    #1; chk("b2b_stall1", st1, 1); chk("b2b_stall0", st0, 1);
    tick();
    chk("b2b_sc1", sc1, 4); chk("b2b_sc0", sc0, 2); chk("b2b_bub1", bub1, 1);

    // Saturation: 19 forwarded launches after dut1 drains its stall.
    clr(); tick(); tick(); tick();
    s0 = 5'd3; u = 2'b01; exr = 5'd3; exw = 1'b1;
    for (int i = 0; i < 19; i++) begin
      tick();
      exp_f0++;
      if (exp_f1 < 15) exp_f1++;
    end
    chk("sat_fc1", fc1, 4'hF); chk("sat_fc1_model", fc1, exp_f1);
    chk("sat_fc0", fc0, exp_f0); chk("sat_sel1", sel1, 4'b0010);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
